// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: arbiter state encoding, response codes,
// the idle PROT value and a small grant-encoding helper.
package axi_lite_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_XFER = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_RD_ADDR = ST_RD_ADDR,
        S_RD_DATA = ST_RD_DATA,
        S_WR_XFER = ST_WR_XFER,
        S_WR_RESP = ST_WR_RESP
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // Convert a master index (0 = S0, 1 = S1) to a one-hot grant vector.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant logic. The grant is combinational from req;
// the last-grant register only moves when the owner accepts the grant.
module rr_arbiter2
    import axi_lite_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // Pick a winner: a lone requester wins, a tie goes to the master not granted last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = idx_to_onehot(~last_q);
            default: gnt = 2'b00;
        endcase
    end

    // Remember who was granted when the grant is actually taken.
    always_comb begin
        last_d = last_q;
        if (update && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register; resets to S0 so S1 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter, one transaction in flight.
// Ownership is decided in IDLE and held until the R or B handshake; once
// granted, all channels are forwarded combinationally to and from M.
module axi_lite_arbiter_2to1
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // master 0 (instruction fetch)
    input  logic [ADDR_W-1:0]     S0_AXI_AWADDR,
    input  logic [2:0]            S0_AXI_AWPROT,
    input  logic                  S0_AXI_AWVALID,
    output logic                  S0_AXI_AWREADY,
    input  logic [DATA_W-1:0]     S0_AXI_WDATA,
    input  logic [DATA_W/8-1:0]   S0_AXI_WSTRB,
    input  logic                  S0_AXI_WVALID,
    output logic                  S0_AXI_WREADY,
    output logic [1:0]            S0_AXI_BRESP,
    output logic                  S0_AXI_BVALID,
    input  logic                  S0_AXI_BREADY,
    input  logic [ADDR_W-1:0]     S0_AXI_ARADDR,
    input  logic [2:0]            S0_AXI_ARPROT,
    input  logic                  S0_AXI_ARVALID,
    output logic                  S0_AXI_ARREADY,
    output logic [DATA_W-1:0]     S0_AXI_RDATA,
    output logic [1:0]            S0_AXI_RRESP,
    output logic                  S0_AXI_RVALID,
    input  logic                  S0_AXI_RREADY,
    // master 1 (data side)
    input  logic [ADDR_W-1:0]     S1_AXI_AWADDR,
    input  logic [2:0]            S1_AXI_AWPROT,
    input  logic                  S1_AXI_AWVALID,
    output logic                  S1_AXI_AWREADY,
    input  logic [DATA_W-1:0]     S1_AXI_WDATA,
    input  logic [DATA_W/8-1:0]   S1_AXI_WSTRB,
    input  logic                  S1_AXI_WVALID,
    output logic                  S1_AXI_WREADY,
    output logic [1:0]            S1_AXI_BRESP,
    output logic                  S1_AXI_BVALID,
    input  logic                  S1_AXI_BREADY,
    input  logic [ADDR_W-1:0]     S1_AXI_ARADDR,
    input  logic [2:0]            S1_AXI_ARPROT,
    input  logic                  S1_AXI_ARVALID,
    output logic                  S1_AXI_ARREADY,
    output logic [DATA_W-1:0]     S1_AXI_RDATA,
    output logic [1:0]            S1_AXI_RRESP,
    output logic                  S1_AXI_RVALID,
    input  logic                  S1_AXI_RREADY,
    // shared slave port
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    // status
    output logic [1:0]            gnt,
    output logic                  busy
);

    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [1:0] req_s;
    logic [1:0] arb_gnt_s;
    logic       arb_update_s;
    logic       win_ar_s;
    logic       own_s;
    logic       in_rd_addr_s, in_rd_data_s, in_wr_xfer_s, in_wr_resp_s;
    logic       aw_fwd_s, w_fwd_s;
    logic       ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
    logic       aw_set_s, w_set_s;

    // A pending AR or AW counts as a request; W alone does not.
    assign req_s    = {S1_AXI_ARVALID | S1_AXI_AWVALID, S0_AXI_ARVALID | S0_AXI_AWVALID};
    assign win_ar_s = arb_gnt_s[1] ? S1_AXI_ARVALID : S0_AXI_ARVALID;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_s),
        .update (arb_update_s),
        .gnt    (arb_gnt_s)
    );

    assign own_s        = gnt_q[1];
    assign in_rd_addr_s = (state_q == S_RD_ADDR);
    assign in_rd_data_s = (state_q == S_RD_DATA);
    assign in_wr_xfer_s = (state_q == S_WR_XFER);
    assign in_wr_resp_s = (state_q == S_WR_RESP);
    assign aw_fwd_s     = in_wr_xfer_s & ~aw_done_q;
    assign w_fwd_s      = in_wr_xfer_s & ~w_done_q;

    // Downstream request side: VALIDs depend only on state, flags and the owner's VALIDs.
    assign M_AXI_ARVALID = in_rd_addr_s & (own_s ? S1_AXI_ARVALID : S0_AXI_ARVALID);
    assign M_AXI_ARADDR  = in_rd_addr_s ? (own_s ? S1_AXI_ARADDR : S0_AXI_ARADDR) : {ADDR_W{1'b0}};
    assign M_AXI_ARPROT  = in_rd_addr_s ? (own_s ? S1_AXI_ARPROT : S0_AXI_ARPROT) : PROT_DEFAULT;
    assign M_AXI_RREADY  = in_rd_data_s & (own_s ? S1_AXI_RREADY : S0_AXI_RREADY);
    assign M_AXI_AWVALID = aw_fwd_s & (own_s ? S1_AXI_AWVALID : S0_AXI_AWVALID);
    assign M_AXI_AWADDR  = aw_fwd_s ? (own_s ? S1_AXI_AWADDR : S0_AXI_AWADDR) : {ADDR_W{1'b0}};
    assign M_AXI_AWPROT  = aw_fwd_s ? (own_s ? S1_AXI_AWPROT : S0_AXI_AWPROT) : PROT_DEFAULT;
    assign M_AXI_WVALID  = w_fwd_s & (own_s ? S1_AXI_WVALID : S0_AXI_WVALID);
    assign M_AXI_WDATA   = w_fwd_s ? (own_s ? S1_AXI_WDATA : S0_AXI_WDATA) : {DATA_W{1'b0}};
    assign M_AXI_WSTRB   = w_fwd_s ? (own_s ? S1_AXI_WSTRB : S0_AXI_WSTRB) : {(DATA_W/8){1'b0}};
    assign M_AXI_BREADY  = in_wr_resp_s & (own_s ? S1_AXI_BREADY : S0_AXI_BREADY);

    // Return paths reach the owner only; the other master sees all zeros.
    assign S0_AXI_ARREADY = gnt_q[0] & in_rd_addr_s & M_AXI_ARREADY;
    assign S0_AXI_RVALID  = gnt_q[0] & in_rd_data_s & M_AXI_RVALID;
    assign S0_AXI_RDATA   = (gnt_q[0] & in_rd_data_s) ? M_AXI_RDATA : {DATA_W{1'b0}};
    assign S0_AXI_RRESP   = (gnt_q[0] & in_rd_data_s) ? M_AXI_RRESP : RESP_OKAY;
    assign S0_AXI_AWREADY = gnt_q[0] & aw_fwd_s & M_AXI_AWREADY;
    assign S0_AXI_WREADY  = gnt_q[0] & w_fwd_s & M_AXI_WREADY;
    assign S0_AXI_BVALID  = gnt_q[0] & in_wr_resp_s & M_AXI_BVALID;
    assign S0_AXI_BRESP   = (gnt_q[0] & in_wr_resp_s) ? M_AXI_BRESP : RESP_OKAY;

    assign S1_AXI_ARREADY = gnt_q[1] & in_rd_addr_s & M_AXI_ARREADY;
    assign S1_AXI_RVALID  = gnt_q[1] & in_rd_data_s & M_AXI_RVALID;
    assign S1_AXI_RDATA   = (gnt_q[1] & in_rd_data_s) ? M_AXI_RDATA : {DATA_W{1'b0}};
    assign S1_AXI_RRESP   = (gnt_q[1] & in_rd_data_s) ? M_AXI_RRESP : RESP_OKAY;
    assign S1_AXI_AWREADY = gnt_q[1] & aw_fwd_s & M_AXI_AWREADY;
    assign S1_AXI_WREADY  = gnt_q[1] & w_fwd_s & M_AXI_WREADY;
    assign S1_AXI_BVALID  = gnt_q[1] & in_wr_resp_s & M_AXI_BVALID;
    assign S1_AXI_BRESP   = (gnt_q[1] & in_wr_resp_s) ? M_AXI_BRESP : RESP_OKAY;

    assign ar_hs_s  = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs_s   = M_AXI_RVALID & M_AXI_RREADY;
    assign aw_hs_s  = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs_s   = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs_s   = M_AXI_BVALID & M_AXI_BREADY;
    assign aw_set_s = aw_done_q | aw_hs_s;
    assign w_set_s  = w_done_q | w_hs_s;

    assign gnt  = gnt_q;
    assign busy = busy_q;

    // Next-state, grant and write-progress flags; reads win when AR and AW are both pending.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        arb_update_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_gnt_s != 2'b00) begin
                    arb_update_s = 1'b1;
                    gnt_d        = arb_gnt_s;
                    state_d      = win_ar_s ? S_RD_ADDR : S_WR_XFER;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (ar_hs_s) begin
                    state_d = S_RD_DATA;
                end else begin
                    state_d = S_RD_ADDR;
                end
            end
            S_RD_DATA: begin
                if (r_hs_s) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                end else begin
                    state_d = S_RD_DATA;
                end
            end
            S_WR_XFER: begin
                if (aw_set_s && w_set_s) begin
                    state_d   = S_WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    state_d   = S_WR_XFER;
                    aw_done_d = aw_set_s;
                    w_done_d  = w_set_s;
                end
            end
            S_WR_RESP: begin
                if (b_hs_s) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                end else begin
                    state_d = S_WR_RESP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                gnt_d     = 2'b00;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, grant, busy and write-progress registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for the 2:1 AXI4-Lite arbiter. The bench plays both masters
// and the slave; inputs change at the falling edge, outputs are checked 1 ns later.
module tb_axi_lite_arbiter_2to1;
    import axi_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0]   awaddr [2];
    logic [2:0]      awprot [2];
    logic            awvalid[2];
    logic            awready[2];
    logic [DW-1:0]   wdata  [2];
    logic [DW/8-1:0] wstrb  [2];
    logic            wvalid [2];
    logic            wready [2];
    logic [1:0]      bresp  [2];
    logic            bvalid [2];
    logic            bready [2];
    logic [AW-1:0]   araddr [2];
    logic [2:0]      arprot [2];
    logic            arvalid[2];
    logic            arready[2];
    logic [DW-1:0]   rdata  [2];
    logic [1:0]      rresp  [2];
    logic            rvalid [2];
    logic            rready [2];

    logic [AW-1:0]   m_awaddr;
    logic [2:0]      m_awprot;
    logic            m_awvalid, m_awready;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_wvalid, m_wready;
    logic [1:0]      m_bresp;
    logic            m_bvalid, m_bready;
    logic [AW-1:0]   m_araddr;
    logic [2:0]      m_arprot;
    logic            m_arvalid, m_arready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rvalid, m_rready;
    logic [1:0]      gnt;
    logic            busy;

    int n_total = 0;
    int n_bad   = 0;

    axi_lite_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .S0_AXI_AWADDR(awaddr[0]), .S0_AXI_AWPROT(awprot[0]), .S0_AXI_AWVALID(awvalid[0]), .S0_AXI_AWREADY(awready[0]),
        .S0_AXI_WDATA(wdata[0]), .S0_AXI_WSTRB(wstrb[0]), .S0_AXI_WVALID(wvalid[0]), .S0_AXI_WREADY(wready[0]),
        .S0_AXI_BRESP(bresp[0]), .S0_AXI_BVALID(bvalid[0]), .S0_AXI_BREADY(bready[0]),
        .S0_AXI_ARADDR(araddr[0]), .S0_AXI_ARPROT(arprot[0]), .S0_AXI_ARVALID(arvalid[0]), .S0_AXI_ARREADY(arready[0]),
        .S0_AXI_RDATA(rdata[0]), .S0_AXI_RRESP(rresp[0]), .S0_AXI_RVALID(rvalid[0]), .S0_AXI_RREADY(rready[0]),
        .S1_AXI_AWADDR(awaddr[1]), .S1_AXI_AWPROT(awprot[1]), .S1_AXI_AWVALID(awvalid[1]), .S1_AXI_AWREADY(awready[1]),
        .S1_AXI_WDATA(wdata[1]), .S1_AXI_WSTRB(wstrb[1]), .S1_AXI_WVALID(wvalid[1]), .S1_AXI_WREADY(wready[1]),
        .S1_AXI_BRESP(bresp[1]), .S1_AXI_BVALID(bvalid[1]), .S1_AXI_BREADY(bready[1]),
        .S1_AXI_ARADDR(araddr[1]), .S1_AXI_ARPROT(arprot[1]), .S1_AXI_ARVALID(arvalid[1]), .S1_AXI_ARREADY(arready[1]),
        .S1_AXI_RDATA(rdata[1]), .S1_AXI_RRESP(rresp[1]), .S1_AXI_RVALID(rvalid[1]), .S1_AXI_RREADY(rready[1]),
        .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
        .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
        .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
        .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
        .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready),
        .gnt(gnt), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Read by 'who'; caller has already driven its ARVALID/ARADDR with the DUT idle.
    task automatic do_read(input int who, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp);
        int oth;
        oth = 1 - who;
        m_arready = 1'b1;
        tick();
        #1;
        chk("rd_gnt", gnt, (who == 1) ? 2'b10 : 2'b01);
        chk("rd_busy", busy, 1'b1);
        chk("rd_m_arvalid", m_arvalid, 1'b1);
        chk("rd_m_araddr", m_araddr, addr);
        chk("rd_m_awvalid", m_awvalid, 1'b0);
        chk("rd_arready_own", arready[who], 1'b1);
        chk("rd_arready_oth", arready[oth], 1'b0);
        chk("rd_awready_own", awready[who], 1'b0);
        tick();
        arvalid[who] = 1'b0;
        m_arready    = 1'b0;
        m_rvalid     = 1'b1;
        m_rdata      = data;
        m_rresp      = resp;
        rready[who]  = 1'b1;
        #1;
        chk("rd_m_arvalid_off", m_arvalid, 1'b0);
        chk("rd_m_rready", m_rready, 1'b1);
        chk("rd_rvalid_own", rvalid[who], 1'b1);
        chk("rd_rdata_own", rdata[who], data);
        chk("rd_rresp_own", rresp[who], resp);
        chk("rd_rvalid_oth", rvalid[oth], 1'b0);
        chk("rd_rdata_oth", rdata[oth], 32'h0000_0000);
        tick();
        m_rvalid    = 1'b0;
        m_rdata     = 32'h0000_0000;
        m_rresp     = RESP_OKAY;
        rready[who] = 1'b0;
        #1;
        chk("rd_end_gnt", gnt, 2'b00);
        chk("rd_end_busy", busy, 1'b0);
    endtask

    // Write by 'who' with AW and W presented together; caller drives them with the DUT idle.
    task automatic do_write(input int who, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        int oth;
        oth = 1 - who;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        tick();
        #1;
        chk("wr_gnt", gnt, (who == 1) ? 2'b10 : 2'b01);
        chk("wr_m_awvalid", m_awvalid, 1'b1);
        chk("wr_m_awaddr", m_awaddr, addr);
        chk("wr_m_wvalid", m_wvalid, 1'b1);
        chk("wr_m_wdata", m_wdata, data);
        chk("wr_m_wstrb", m_wstrb, strb);
        chk("wr_awready_own", awready[who], 1'b1);
        chk("wr_wready_own", wready[who], 1'b1);
        chk("wr_awready_oth", awready[oth], 1'b0);
        tick();
        awvalid[who] = 1'b0;
        wvalid[who]  = 1'b0;
        m_awready    = 1'b0;
        m_wready     = 1'b0;
        m_bvalid     = 1'b1;
        m_bresp      = resp;
        bready[who]  = 1'b1;
        #1;
        chk("wr_m_bready", m_bready, 1'b1);
        chk("wr_bvalid_own", bvalid[who], 1'b1);
        chk("wr_bresp_own", bresp[who], resp);
        chk("wr_bvalid_oth", bvalid[oth], 1'b0);
        chk("wr_m_awvalid_off", m_awvalid, 1'b0);
        tick();
        m_bvalid    = 1'b0;
        m_bresp     = RESP_OKAY;
        bready[who] = 1'b0;
        #1;
        chk("wr_end_gnt", gnt, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            awaddr[i] = '0; awprot[i] = 3'b000; awvalid[i] = 1'b0;
            wdata[i] = '0; wstrb[i] = 4'h0; wvalid[i] = 1'b0; bready[i] = 1'b0;
            araddr[i] = '0; arprot[i] = 3'b000; arvalid[i] = 1'b0; rready[i] = 1'b0;
        end
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = RESP_OKAY;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0000_0000; m_rresp = RESP_OKAY;

        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_m_awvalid", m_awvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // S0 read only; no M VALID during the arbitration cycle
        arvalid[0] = 1'b1;
        araddr[0]  = 32'h0000_0010;
        #1;
        chk("t1_arb_m_arvalid", m_arvalid, 1'b0);
        chk("t1_arb_gnt", gnt, 2'b00);
        do_read(0, 32'h0000_0010, 32'hDEAD_BEEF, RESP_OKAY);

        // simultaneous reads after reset: S1 first, then S0 beats a re-requesting S1
        do_reset();
        arvalid[0] = 1'b1; araddr[0] = 32'h0000_0020;
        arvalid[1] = 1'b1; araddr[1] = 32'h0000_0030;
        do_read(1, 32'h0000_0030, 32'h1111_1111, RESP_OKAY);
        arvalid[1] = 1'b1; araddr[1] = 32'h0000_0034;
        do_read(0, 32'h0000_0020, 32'h2222_2222, RESP_OKAY);
        do_read(1, 32'h0000_0034, 32'h3333_3333, RESP_EXOKAY);

        // S1 write, AW one cycle ahead of W
        awvalid[1] = 1'b1; awaddr[1] = 32'h0000_0100;
        m_awready = 1'b1; m_wready = 1'b1; bready[1] = 1'b1;
        #1;
        chk("t3_arb_m_awvalid", m_awvalid, 1'b0);
        tick();
        #1;
        chk("t3_gnt", gnt, 2'b10);
        chk("t3_m_awvalid", m_awvalid, 1'b1);
        chk("t3_m_awaddr", m_awaddr, 32'h0000_0100);
        chk("t3_awready", awready[1], 1'b1);
        chk("t3_m_wvalid_early", m_wvalid, 1'b0);
        tick();
        awvalid[1] = 1'b0;
        wvalid[1] = 1'b1; wdata[1] = 32'h1234_5678; wstrb[1] = 4'b0011;
        #1;
        chk("t3_aw_blocked", m_awvalid, 1'b0);
        chk("t3_awready_done", awready[1], 1'b0);
        chk("t3_m_wvalid", m_wvalid, 1'b1);
        chk("t3_m_wdata", m_wdata, 32'h1234_5678);
        chk("t3_m_wstrb", m_wstrb, 4'b0011);
        chk("t3_no_resp_yet", m_bready, 1'b0);
        tick();
        wvalid[1] = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b1; m_bresp = RESP_OKAY;
        #1;
        chk("t3_m_bready", m_bready, 1'b1);
        chk("t3_bvalid", bvalid[1], 1'b1);
        chk("t3_bresp", bresp[1], RESP_OKAY);
        chk("t3_bvalid_s0", bvalid[0], 1'b0);
        chk("t3_m_wvalid_off", m_wvalid, 1'b0);
        tick();
        m_bvalid = 1'b0; bready[1] = 1'b0;
        #1;
        chk("t3_end_gnt", gnt, 2'b00);
        chk("t3_end_bvalid", bvalid[1], 1'b0);

        // S1 AR and AW together: read first, then the write
        arvalid[1] = 1'b1; araddr[1] = 32'h0000_0200;
        awvalid[1] = 1'b1; awaddr[1] = 32'h0000_0300;
        wvalid[1] = 1'b1; wdata[1] = 32'hCAFE_F00D; wstrb[1] = 4'hF;
        m_awready = 1'b1;
        do_read(1, 32'h0000_0200, 32'h4444_4444, RESP_OKAY);
        do_write(1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, RESP_OKAY);

        // slow read for S0 holds off S1's write; S1 then gets SLVERR unchanged
        arvalid[0] = 1'b1; araddr[0] = 32'h0000_0040;
        m_arready = 1'b1;
        tick();
        #1;
        chk("t5_gnt", gnt, 2'b01);
        tick();
        arvalid[0] = 1'b0; m_arready = 1'b0; rready[0] = 1'b1;
        awvalid[1] = 1'b1; awaddr[1] = 32'h0000_0400;
        wvalid[1] = 1'b1; wdata[1] = 32'h55AA_55AA; wstrb[1] = 4'hF;
        m_awready = 1'b1; m_wready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_wait_awready", awready[1], 1'b0);
            chk("t5_wait_m_awvalid", m_awvalid, 1'b0);
            chk("t5_wait_gnt", gnt, 2'b01);
            tick();
        end
        m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; m_rresp = RESP_OKAY;
        #1;
        chk("t5_rdata", rdata[0], 32'h0BAD_F00D);
        chk("t5_rvalid", rvalid[0], 1'b1);
        chk("t5_awready_rd", awready[1], 1'b0);
        tick();
        m_rvalid = 1'b0; m_rdata = 32'h0000_0000; rready[0] = 1'b0;
        #1;
        chk("t5_idle_gnt", gnt, 2'b00);
        chk("t5_idle_awready", awready[1], 1'b0);
        do_write(1, 32'h0000_0400, 32'h55AA_55AA, 4'hF, RESP_SLVERR);

        // asynchronous reset during RD_DATA
        arvalid[0] = 1'b1; araddr[0] = 32'h0000_0050;
        m_arready = 1'b1;
        tick();
        tick();
        arvalid[0] = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h7777_7777; rready[0] = 1'b1;
        #1;
        chk("t6_pre_rvalid", rvalid[0], 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rvalid", rvalid[0], 1'b0);
        chk("t6_rst_rdata", rdata[0], 32'h0000_0000);
        chk("t6_rst_gnt", gnt, 2'b00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_m_rready", m_rready, 1'b0);
        m_rvalid = 1'b0; m_rdata = 32'h0000_0000; rready[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        arvalid[0] = 1'b1; araddr[0] = 32'h0000_0060;
        do_read(0, 32'h0000_0060, 32'h600D_600D, RESP_DECERR);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
# axi_lite_arbiter_2to1

Two-master to one-slave AXI4-Lite arbiter with one transaction outstanding at a time. It lets the instruction-fetch master (S0, imem access unit) and the data master (S1, dmem access unit) share a single unified memory or peripheral slave port (M). Arbitration is round-robin. The grant is held for a whole transaction, from address acceptance to the R or B handshake.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports; strobe width is DATA_W/8
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- S0_AXI_AW{ADDR,PROT,VALID} in ADDR_W/3/1; S0_AXI_AWREADY out 1  master 0 write address
- S0_AXI_W{DATA,STRB,VALID} in DATA_W/DATA_W/8/1; S0_AXI_WREADY out 1  master 0 write data
- S0_AXI_B{RESP,VALID} out 2/1; S0_AXI_BREADY in 1  master 0 write response
- S0_AXI_AR{ADDR,PROT,VALID} in ADDR_W/3/1; S0_AXI_ARREADY out 1  master 0 read address
- S0_AXI_R{DATA,RESP,VALID} out DATA_W/2/1; S0_AXI_RREADY in 1  master 0 read data
- S1_AXI_* (same 5 channels, same widths)  master 1 (data side)
- M_AXI_* (same 5 channels, directions mirrored)  shared downstream slave port
- gnt  out  2  one-hot current owner (bit0 = S0, bit1 = S1); 0 when idle
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP.
- Request per master: req_i = ARVALID_i | AWVALID_i. A write request also requires WVALID_i, or is simply awaiting it; AWVALID_i alone is enough to request.
- IDLE arbitration:
  - One requester: it wins.
  - Both request: the master not granted last wins. The last-grant register resets to S0, so S1 wins the first tie.
  - Winner has both AR and AW pending: read first. Go to RD_ADDR if ARVALID, else WR_XFER.
  - gnt and the channel direction register on the IDLE->busy transition.
- RD_ADDR: forward the owner's AR to M; ARREADY returns to the owner only. On AR handshake go to RD_DATA.
- RD_DATA: forward M R channel to the owner; RREADY comes from the owner. On R handshake go to IDLE and clear gnt.
- WR_XFER: forward AW and W independently. Flags aw_done/w_done set on each handshake and block re-forwarding. When both are set (same cycle allowed), go to WR_RESP.
- WR_RESP: forward B to the owner. On B handshake go to IDLE and clear gnt.
- Non-owner master: all READY and response VALID outputs are 0, and its request stays pending untouched.
- M outputs when idle or not forwarding: all VALID = 0; address/data/strb/prot = 0.
- RESP is passed through unmodified, including SLVERR/DECERR. The block never generates its own responses.
- Reset, including mid-transaction: state IDLE, gnt = 0, busy = 0, aw_done = w_done = 0, last-grant = S0, all VALID/READY outputs 0. In-flight M transactions are abandoned; the system resets the slave together with this block.

## Timing
- Arbitration costs 1 cycle: request seen in IDLE at cycle N, M_AXI_ARVALID/AWVALID high at N+1.
- After the grant all forwarding is combinational, so there is zero added latency on READY, R and B.
- Minimum read occupancy is 3 cycles: IDLE, RD_ADDR with same-cycle ARREADY, RD_DATA with same-cycle RVALID&RREADY. A back-to-back read from the other master starts on the next IDLE cycle.
- Minimum write occupancy is 3 cycles (IDLE, WR_XFER, WR_RESP).
- No combinational path from any M READY to any M VALID.

## Structure
- Shared package axi_lite_pkg: state encoding (3-bit localparams), RESP codes OKAY/EXOKAY/SLVERR/DECERR, and the PROT default 3'b000.
- One sub-module, rr_arbiter2: 2-input round-robin grant logic with a last-grant register. It is reused later for a DMA third master.
- Channel muxing stays inline in the top module.

## Test plan
- S0 read only, ARADDR 0x0000_0010; slave returns 0xDEAD_BEEF OKAY -> S0 gets RDATA 0xDEAD_BEEF; gnt goes 01 then 00; S1 outputs stay 0 throughout.
- S0 and S1 assert ARVALID in the same cycle after reset -> S1 served first (gnt = 10), then S0. A second simultaneous pair alternates to S0 first.
- S1 write to 0x0000_0100, data 0x1234_5678, strb 4'b0011. AW one cycle before W, slave BRESP OKAY -> M sees both; single B to S1; state goes to WR_RESP only after the W handshake.
- S1 asserts AR and AW together -> the read completes before the write; the write then completes without being re-arbitrated away.
- Slave holds RVALID low 5 cycles while S0 owns the bus and S1 requests a write -> S1 sees AWREADY = 0 until S0's R handshake, then the write proceeds. The slave returns SLVERR, which reaches S1 unchanged.
- rst_n asserted during RD_DATA -> all outputs drop to 0 asynchronously. After release, the first request from S0 is granted within 1 cycle.
